// File: rtl/seg_readback.sv
// Rebuilds the 3-digit decimal value shown on a multiplexed 7-segment bus and publishes it once scans agree.
// Latency: input register, SETTLE-cycle capture per digit, results register one cycle after the final capture.
// No backpressure: passive monitor, always accepts the bus; outputs are status levels and single-cycle pulses.
module seg_readback #(
  parameter int unsigned SETTLE       = 2,
  parameter int unsigned STABLE_SCANS = 2,
  parameter int unsigned IDLE_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_COM,
  input  logic [7:0] seg_DATA,
  output logic [7:0] value,
  output logic       valid,
  output logic       value_upd,
  output logic       scan_done,
  output logic       blank,
  output logic       error
);

  localparam logic [3:0]  SETTLE_W = 4'(SETTLE);
  localparam logic [2:0]  STABLE_W = 3'(STABLE_SCANS);
  localparam logic [15:0] IDLE_W   = 16'(IDLE_TIMEOUT);

  logic [7:0]      com_q, dat_q, prev_com_q, prev_dat_q;
  logic [7:0]      com_d, dat_d, prev_com_d, prev_dat_d;
  logic [3:0]      settle_q, settle_d;
  logic            taken_q, taken_d;
  logic [2:0][3:0] slot_q, slot_d;
  logic [2:0]      bad_q, bad_d;
  logic [2:0]      seen_q, seen_d;
  logic [9:0]      last_q, last_d;
  logic [2:0]      match_q, match_d;
  logic [15:0]     idle_q, idle_d;
  logic [7:0]      value_q, value_d;
  logic            valid_q, valid_d, upd_q, upd_d, done_q, done_d;
  logic            blank_q, blank_d, err_q, err_d;

  logic       sel, same, cap, complete, timeout, scan_bad, dig_bad;
  logic [2:0] sel_oh;
  logic [3:0] dig;
  logic [9:0] h10, t10, o10, cand;

  // Decode digit position from COM and the digit from the segments (dp ignored)
  always_comb begin
    sel_oh = 3'b000;
    case (com_q)
      8'hFE:   sel_oh = 3'b001;
      8'hFD:   sel_oh = 3'b010;
      8'hFB:   sel_oh = 3'b100;
      default: sel_oh = 3'b000;
    endcase
    sel = |sel_oh;
    dig_bad = 1'b0;
    case ({dat_q[7:1], 1'b0})
      8'hFC:   dig = 4'd0;
      8'h60:   dig = 4'd1;
      8'hDA:   dig = 4'd2;
      8'hF2:   dig = 4'd3;
      8'h66:   dig = 4'd4;
      8'hB6:   dig = 4'd5;
      8'hBE:   dig = 4'd6;
      8'hE0:   dig = 4'd7;
      8'hFE:   dig = 4'd8;
      8'hF6:   dig = 4'd9;
      default: begin dig = 4'd0; dig_bad = 1'b1; end
    endcase
  end

  // Candidate value h*100 + t*10 + o as shift-add on the stored slots
  always_comb begin
    h10 = {6'd0, slot_q[2]};
    t10 = {6'd0, slot_q[1]};
    o10 = {6'd0, slot_q[0]};
    cand = (h10 << 6) + (h10 << 5) + (h10 << 2) + (t10 << 3) + (t10 << 1) + o10;
    scan_bad = (|bad_q) || (cand > 10'd255);
  end

  // Next state: glitch filter, digit capture, scan completion, stability check, idle detection
  always_comb begin
    com_d      = seg_COM;
    dat_d      = seg_DATA;
    prev_com_d = com_q;
    prev_dat_d = dat_q;

    same = (com_q == prev_com_q) && (dat_q == prev_dat_q);
    if (!same)
      settle_d = 4'd1;
    else if (sel && settle_q != 4'hF)
      settle_d = settle_q + 4'd1;
    else
      settle_d = settle_q;

    // taken_q remembers that the current dwell already produced its capture
    taken_d = same ? taken_q : 1'b0;
    cap     = sel && !taken_d && (settle_d >= SETTLE_W);
    taken_d = taken_d | cap;

    complete = (seen_q == 3'b111);
    slot_d   = slot_q;
    bad_d    = bad_q;
    seen_d   = complete ? 3'b000 : seen_q;
    for (int i = 0; i < 3; i++) begin
      if (cap && sel_oh[i]) begin
        slot_d[i] = dig;
        bad_d[i]  = dig_bad;
        seen_d[i] = 1'b1;
      end
    end

    done_d  = 1'b0;
    err_d   = 1'b0;
    upd_d   = 1'b0;
    last_d  = last_q;
    match_d = match_q;
    value_d = value_q;
    valid_d = valid_q;
    if (complete) begin
      done_d = 1'b1;
      if (scan_bad) begin
        err_d   = 1'b1;
        match_d = 3'd0;
      end else begin
        if (cand == last_q) begin
          if (match_q < STABLE_W)
            match_d = match_q + 3'd1;
        end else begin
          last_d  = cand;
          match_d = 3'd1;
        end
        if (match_d == STABLE_W && (!valid_q || cand[7:0] != value_q)) begin
          value_d = cand[7:0];
          valid_d = 1'b1;
          upd_d   = 1'b1;
        end
      end
    end

    // Idle counter saturates so the timeout fires once per idle period
    if (sel)
      idle_d = 16'd0;
    else if (idle_q != IDLE_W)
      idle_d = idle_q + 16'd1;
    else
      idle_d = idle_q;
    timeout = (idle_d == IDLE_W) && (idle_q != IDLE_W);
    blank_d = sel ? 1'b0 : (timeout | blank_q);
    if (timeout) begin
      valid_d = 1'b0;
      seen_d  = 3'b000;
      match_d = 3'd0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      com_q      <= 8'hFF;
      dat_q      <= 8'h00;
      prev_com_q <= 8'hFF;
      prev_dat_q <= 8'h00;
      settle_q   <= 4'd0;
      taken_q    <= 1'b0;
      slot_q     <= '0;
      bad_q      <= 3'b000;
      seen_q     <= 3'b000;
      last_q     <= 10'd0;
      match_q    <= 3'd0;
      idle_q     <= 16'd0;
      value_q    <= 8'd0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      done_q     <= 1'b0;
      blank_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      com_q      <= com_d;
      dat_q      <= dat_d;
      prev_com_q <= prev_com_d;
      prev_dat_q <= prev_dat_d;
      settle_q   <= settle_d;
      taken_q    <= taken_d;
      slot_q     <= slot_d;
      bad_q      <= bad_d;
      seen_q     <= seen_d;
      last_q     <= last_d;
      match_q    <= match_d;
      idle_q     <= idle_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      done_q     <= done_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
    end
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign value_upd = upd_q;
  assign scan_done = done_q;
  assign blank     = blank_q;
  assign error     = err_q;

endmodule

// File: tb/tb_seg_readback.sv
// Directed bench for seg_readback: drives multiplexed scans, scoreboards each scan result.
// Latency: expectations are queued when a scan is driven and popped on scan_done.
// No backpressure: the DUT is a passive monitor.
module tb_seg_readback;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_COM, seg_DATA;
  logic [7:0] value;
  logic       valid, value_upd, scan_done, blank, error;

  always #5 clk = ~clk;

  seg_readback #(.SETTLE(2), .STABLE_SCANS(2), .IDLE_TIMEOUT(4096)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_COM   (seg_COM),
    .seg_DATA  (seg_DATA),
    .value     (value),
    .valid     (valid),
    .value_upd (value_upd),
    .scan_done (scan_done),
    .blank     (blank),
    .error     (error)
  );

  typedef struct {
    logic [7:0] value;
    logic       valid;
    logic       err;
    logic       upd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, fails = 0;
  int   upd_seen = 0, err_seen = 0, upd_exp = 0, err_exp = 0;
  int   m_last = 0, m_match = 0, m_value = 0;
  bit   m_valid = 1'b0;

  localparam int DWELL = 8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'hFC;
      1: return 8'h60;
      2: return 8'hDA;
      3: return 8'hF2;
      4: return 8'h66;
      5: return 8'hB6;
      6: return 8'hBE;
      7: return 8'hE0;
      8: return 8'hFE;
      9: return 8'hF6;
      default: return 8'h02;
    endcase
  endfunction

  task automatic model_reset();
    m_last = 0; m_match = 0; m_value = 0; m_valid = 1'b0;
  endtask

  // Reference behaviour of one complete scan; digits above 9 stand for an undecodable code
  task automatic model_scan(input int h, input int t, input int o);
    exp_t e;
    int   cand;
    bit   bad;
    bad  = (h > 9) || (t > 9) || (o > 9);
    cand = h * 100 + t * 10 + o;
    e.err = 1'b0;
    e.upd = 1'b0;
    if (bad || cand > 255) begin
      e.err   = 1'b1;
      m_match = 0;
      err_exp++;
    end else begin
      if (cand == m_last) begin
        if (m_match < 2) m_match++;
      end else begin
        m_last  = cand;
        m_match = 1;
      end
      if (m_match == 2 && (!m_valid || cand != m_value)) begin
        m_value = cand;
        m_valid = 1'b1;
        e.upd   = 1'b1;
        upd_exp++;
      end
    end
    e.value = m_value[7:0];
    e.valid = m_valid;
    sb_q.push_back(e);
  endtask

  task automatic hold(input logic [7:0] c, input logic [7:0] d, input int n);
    seg_COM  = c;
    seg_DATA = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input int h, input int t, input int o);
    model_scan(h, t, o);
    hold(8'hFE, seg_code(o), DWELL);
    hold(8'hFD, seg_code(t), DWELL);
    hold(8'hFB, seg_code(h), DWELL);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_value"}, value, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_upd"}, value_upd, 0);
    chk({tag, "_done"}, scan_done, 0);
    chk({tag, "_blank"}, blank, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  // Scoreboard: every scan_done pops the expectation queued when that scan was driven
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (value_upd === 1'b1) upd_seen++;
      if (error === 1'b1) err_seen++;
      if (scan_done === 1'b1) begin
        checks++;
        assert (sb_q.size() > 0) else begin
          fails++;
          $error("FAIL unexpected_scan_done: observed value %0d with no scan pending", value);
        end
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sd_value", value, e.value);
          chk("sd_valid", valid, e.valid);
          chk("sd_error", error, e.err);
          chk("sd_upd", value_upd, e.upd);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    seg_COM = 8'hFF;
    seg_DATA = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    model_reset();

    // 123 repeatedly: valid after the second scan, single update
    scan(1, 2, 3);
    chk("first_scan_valid", valid, 0);
    scan(1, 2, 3);
    chk("second_scan_value", value, 123);
    chk("second_scan_valid", valid, 1);
    scan(1, 2, 3);
    chk("upd_count_123", upd_seen, 1);

    // Value changes take two agreeing scans
    scan(0, 4, 2);
    chk("042_first_scan_value", value, 123);
    scan(0, 4, 2);
    chk("042_value", value, 42);
    scan(2, 5, 5);
    scan(2, 5, 5);
    chk("255_value", value, 255);
    scan(0, 0, 9);
    scan(0, 0, 9);
    chk("009_value", value, 9);
    chk("upd_count_changes", upd_seen, 4);

    // Bad tens code during one scan
    scan(1, 2, 3);
    scan(1, 2, 3);
    scan(1, 10, 3);
    chk("bad_code_value", value, 123);
    chk("bad_code_valid", valid, 1);
    chk("bad_code_errors", err_seen, 1);
    scan(1, 2, 3);
    scan(1, 2, 3);
    chk("after_bad_upd_count", upd_seen, 5);

    // 256 overflows every scan
    scan(2, 5, 6);
    scan(2, 5, 6);
    scan(2, 5, 6);
    chk("overflow_errors", err_seen, 4);
    chk("overflow_valid", valid, 1);
    chk("overflow_value", value, 123);

    // Single-cycle hundreds glitch, then idle into blank
    hold(8'hFF, 8'h00, 2);
    hold(8'hFB, seg_code(1), 1);
    hold(8'hFF, 8'h00, 4090);
    chk("pre_timeout_blank", blank, 0);
    chk("pre_timeout_valid", valid, 1);
    hold(8'hFF, 8'h00, 10);
    chk("timeout_blank", blank, 1);
    chk("timeout_valid", valid, 0);
    chk("timeout_value_held", value, 123);
    m_valid = 1'b0;
    m_match = 0;

    // Resume: blank clears immediately, valid after two scans
    scan(1, 2, 3);
    chk("resume_blank", blank, 0);
    chk("resume_first_valid", valid, 0);
    scan(1, 2, 3);
    chk("resume_valid", valid, 1);
    chk("resume_value", value, 123);

    // Reset early in the hundreds dwell discards the partial scan
    hold(8'hFE, seg_code(3), DWELL);
    hold(8'hFD, seg_code(2), DWELL);
    seg_COM = 8'hFB;
    seg_DATA = seg_code(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk_all_zero("midscan_reset");
    hold(8'hFB, seg_code(1), DWELL - 2);
    scan(1, 2, 3);
    chk("post_reset_first_valid", valid, 0);
    scan(1, 2, 3);
    chk("post_reset_valid", valid, 1);
    chk("post_reset_value", value, 123);

    hold(8'hFF, 8'h00, 4);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("upd_total", upd_seen, upd_exp);
    chk("err_total", err_seen, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg_readback.md
# seg_readback

Readback monitor for the multiplexed 7-segment bus driven by `display_unit`. It watches `seg_COM`/`seg_DATA` and rebuilds the three displayed decimal digits (ones, tens, hundreds). It converts them to an 8-bit binary value and publishes that value only after consecutive complete scans agree. It sits beside the display driver as an on-chip self-check, and lets benches observe the display without decoding it themselves.

## Interface
- `SETTLE`, 2: consecutive cycles one `(seg_COM, seg_DATA)` pair must stay unchanged before its digit is captured (glitch rejection); range 1..15.
- `STABLE_SCANS`, 2: identical consecutive complete scans required before `value` updates; range 1..7.
- `IDLE_TIMEOUT`, 4096: cycles with no digit selected before the display is declared blank; range 2..65535.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `seg_COM`  in  8  digit select, active-low; bit0 ones, bit1 tens, bit2 hundreds.
- `seg_DATA`  in  8  segments, active-high; bit7=a … bit1=g, bit0=dp.
- `value`  out  8  last stable displayed value, binary.
- `valid`  out  1  `value` reflects a confirmed display reading.
- `value_upd`  out  1  one-cycle pulse when `value` changes or `valid` rises.
- `scan_done`  out  1  one-cycle pulse per complete three-digit scan.
- `blank`  out  1  display idle/disabled for `IDLE_TIMEOUT` cycles.
- `error`  out  1  one-cycle pulse for an undecodable digit or a scan value above 255.

## Operation
- Input stage: `seg_COM`/`seg_DATA` registered once; all logic uses the registered copies.
- Position decode: a digit is selected only for COM = `FE`, `FD` or `FB`. Any other pattern, including `FF`, multiple lows or bits 3..7 low, selects no digit.
- Segment decode: dp (bit0) is masked. `FC`=0, `60`=1, `DA`=2, `F2`=3, `66`=4, `B6`=5, `BE`=6, `E0`=7, `FE`=8, `F6`=9. Any other code is marked bad.
- Settle counter: increments while the registered pair equals the previous cycle's pair and a digit is selected. It resets to 1 on any change.
  - When the count reaches `SETTLE`, the digit and bad flag are stored in the slot for that position and `seen[pos]` is set.
  - Each dwell captures only once, even if it lasts longer.
- Scan completion: when `seen` becomes all ones, the cycle after the last capture:
  - `scan_done` pulses and `seen` clears.
  - candidate = h·100 + t·10 + o, computed in 10 bits as shift-add: h<<6 + h<<5 + h<<2 + t<<3 + t<<1 + o.
  - If any slot is bad or candidate > 255, `error` pulses, the match count clears and `value`/`valid` are unchanged.
- Stability check:
  - If the candidate equals the stored last candidate, the match count increments and saturates at `STABLE_SCANS`.
  - Otherwise the candidate is stored as the new last candidate and the match count becomes 1.
  - When the match count equals `STABLE_SCANS` and (`valid`=0 or candidate≠`value`), then `value`←candidate, `valid`←1 and `value_upd` pulses.
- Idle detection: a counter increments on cycles with no digit selected and clears on any selected cycle.
  - On reaching `IDLE_TIMEOUT`: `blank`←1, `valid`←0, `seen` cleared, match count cleared. `value` holds its old contents.
  - `blank` clears on the first selected cycle.
  - `valid` returns only via the stability check.
- Digits may arrive in any order; a slot that is recaptured before the scan completes is overwritten.

## Timing
- Reset (`rst`=0 at a `clk` edge): `value`=0, `valid`=0, `value_upd`=0, `scan_done`=0, `blank`=0, `error`=0.
  - All counters, slots, `seen` and the last candidate clear.
  - Reset mid-scan discards the partial scan.
- Capture latency: a digit is captured `SETTLE` cycles after its pair first appears on the bus, counting the 1-cycle input register.
- Output latency: `scan_done`, `error`, `value`, `valid` and `value_upd` all register in the same edge, one cycle after the final capture.
- With `STABLE_SCANS`=2, the first `valid` follows the second matching scan.
- All pulses are exactly one cycle wide; `error` and `value_upd` are never asserted together.
- Simultaneous idle timeout and scan completion cannot occur, because a completion requires a selected cycle.

## Test plan
- The bench model scans FE→FD→FB with an 8-cycle dwell and shows 123. After reset: one `scan_done` per scan; on the second scan, `value`=123, `valid`=1 and `value_upd` pulses once; later scans give no `value_upd`.
- Show 123 for 3 scans, then 042. `value` becomes 42 two scans after the change, with exactly one `value_upd`. Repeat with 255 and 009, expecting 255 and 9.
- Tens digit `seg_DATA`=`02` (bad code) during one scan: `error` pulses, `value` stays 123 and `valid` stays 1. Two scans after the bad one, `value_upd` does not fire because the value is unchanged.
- Show digits 2,5,6, i.e. 256: `error` on every scan, `valid` unchanged, `value` never 256.
- Drive a 1-cycle COM=`FB` glitch with `SETTLE`=2: no capture and no `scan_done`.
  - Then hold `seg_COM`=`FF`/`seg_DATA`=`00` for 4096 cycles: `blank`=1, `valid`=0.
  - Resume 123: `blank` clears and `valid` returns after 2 scans.
- Assert `rst`=0 for 1 cycle midway through the hundreds dwell: all outputs 0. The next full scan alone does not set `valid`; the second one does.
